// File: rtl/regfile_dump_tx.sv
// Walks the register file debug port and sends each 32-bit word as UART 8N1 bytes, LSB byte first; start is ignored while busy.
// Optional REG_DUMP_HEADER_EN: each word is preceded by a {3'b000, index} header frame.
module regfile_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
`ifdef REG_DUMP_HEADER_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [2:0] {
        IDLE, ADDR, WAIT, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT
    } state_t;

    state_t            state, state_nx;
    logic [4:0]        reg_idx, reg_idx_nx, dbg_addr_nx;
    logic [31:0]       word, word_nx;
    logic [2:0]        byte_cnt, byte_cnt_nx, bit_cnt, bit_cnt_nx;
    logic [BAUD_W-1:0] baud, baud_nx;
    logic              tx_nx, busy_nx, done_nx, baud_end;
    logic [7:0]        cur_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            reg_idx  <= '0;
            dbg_addr <= '0;
            word     <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            baud     <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            reg_idx  <= reg_idx_nx;
            dbg_addr <= dbg_addr_nx;
            word     <= word_nx;
            byte_cnt <= byte_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            baud     <= baud_nx;
            tx       <= tx_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        reg_idx_nx  = reg_idx;
        dbg_addr_nx = dbg_addr;
        word_nx     = word;
        byte_cnt_nx = byte_cnt;
        bit_cnt_nx  = bit_cnt;
        baud_nx     = baud;
        busy_nx     = busy;
        baud_end    = (baud == BAUD_LAST);

        case (state)
            IDLE: begin
                if (start) begin
                    reg_idx_nx  = '0;
                    dbg_addr_nx = '0;
                    busy_nx     = 1'b1;
                    state_nx    = ADDR;
                end
            end
            ADDR: begin
                dbg_addr_nx = reg_idx;
                state_nx    = WAIT;
            end
            WAIT: state_nx = LOAD;
            LOAD: begin
                word_nx     = dbg_data;
                byte_cnt_nx = '0;
                baud_nx     = '0;
                state_nx    = START_BIT;
            end
            START_BIT: begin
                baud_nx = baud_end ? '0 : baud + 1'b1;
                if (baud_end) begin
                    bit_cnt_nx = '0;
                    state_nx   = DATA_BITS;
                end
            end
            DATA_BITS: begin
                baud_nx = baud_end ? '0 : baud + 1'b1;
                if (baud_end) begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = STOP_BIT;
                end
            end
            STOP_BIT: begin
                baud_nx = baud_end ? '0 : baud + 1'b1;
                if (baud_end) begin
                    if (byte_cnt != LAST_BYTE) begin
                        byte_cnt_nx = byte_cnt + 3'd1;
`ifdef REG_DUMP_HEADER_EN
                        // the header frame does not consume the captured word
                        if (byte_cnt != 3'd0) word_nx = word >> 8;
`else
                        word_nx = word >> 8;
`endif
                        state_nx = START_BIT;
                    end else begin
                        state_nx = NEXT;
                    end
                end
            end
            NEXT: begin
                if (reg_idx == LAST_REG) begin
                    busy_nx     = 1'b0;
                    dbg_addr_nx = '0;
                    state_nx    = IDLE;
                end else begin
                    reg_idx_nx  = reg_idx + 5'd1;
                    dbg_addr_nx = reg_idx + 5'd1;
                    state_nx    = ADDR;
                end
            end
            default: state_nx = IDLE;
        endcase

        // tx and done are registered from next-state values so they line up with the state they belong to
        done_nx = (state_nx == NEXT) && (reg_idx == LAST_REG);
`ifdef REG_DUMP_HEADER_EN
        cur_byte = (byte_cnt_nx == 3'd0) ? {3'b000, reg_idx_nx} : word_nx[7:0];
`else
        cur_byte = word_nx[7:0];
`endif
        case (state_nx)
            START_BIT: tx_nx = 1'b0;
            DATA_BITS: tx_nx = cur_byte[bit_cnt_nx];
            default:   tx_nx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: a 1-register and a 32-register instance at 4 clocks per bit,
// each fed by a one-stage registered debug-read model; tx is recorded per cycle and UART-decoded.
module tb_regfile_dump_tx;
    localparam int CPB = 4;
`ifdef REG_DUMP_HEADER_EN
    localparam int FRAMES = 5;
`else
    localparam int FRAMES = 4;
`endif
    localparam int FRAME_CYC = 10 * CPB;
    localparam int WORD_CYC  = FRAMES * FRAME_CYC + 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a = '0, data_b = '0;
    logic        tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    logic [31:0] mem_a = 32'h0000_00F8;

    logic        rec_tx[$], rec_done[$], rec_busy[$];
    logic [4:0]  rec_addr[$];
    byte unsigned dec_byte[$];
    int          dec_pos[$];
    int          checks = 0, errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        data_a <= (addr_a == 5'd0) ? mem_a : 32'hDEAD_BEEF;
        data_b <= 32'hA500_0000 + {27'd0, addr_b};
    end

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(1)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .dbg_addr(addr_a),
        .dbg_data(data_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    regfile_dump_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(32)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .dbg_addr(addr_b),
        .dbg_data(data_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // Sample j is taken at the negedge following start-accept edge + j.
    task automatic record(input bit sel, input int ncyc, input int restart_at, input int poke_at);
        rec_tx.delete(); rec_done.delete(); rec_busy.delete(); rec_addr.delete();
        @(posedge clock); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clock);
            rec_tx.push_back(sel ? tx_b : tx_a);
            rec_done.push_back(sel ? done_b : done_a);
            rec_busy.push_back(sel ? busy_b : busy_a);
            rec_addr.push_back(sel ? addr_b : addr_a);
            if (j == restart_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (j == restart_at + 1) begin start_a = 1'b0; start_b = 1'b0; end
            if (j == poke_at) mem_a = 32'hFFFF_FFFF;
        end
    endtask

    task automatic decode();
        int j;
        byte unsigned b;
        j = 0;
        b = 0;
        dec_byte.delete(); dec_pos.delete();
        while (j + FRAME_CYC <= rec_tx.size()) begin
            if (rec_tx[j] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = rec_tx[j + (k + 1) * CPB + CPB / 2];
                dec_byte.push_back(b);
                dec_pos.push_back(j);
                j = j + 9 * CPB + CPB / 2;
            end else begin
                j++;
            end
        end
    endtask

    task automatic test_reset();
        int low_cnt, done_cnt;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL reset tx_a: got %b, expected 1", tx_a); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset busy_a: got %b, expected 0", busy_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset done_a: got %b, expected 0", done_a); end
        checks++; if (addr_a !== 5'd0)  begin errors++; $display("FAIL reset dbg_addr_a: got %0d, expected 0", addr_a); end
        checks++; if (tx_b !== 1'b1)    begin errors++; $display("FAIL reset tx_b: got %b, expected 1", tx_b); end
        checks++; if (busy_b !== 1'b0)  begin errors++; $display("FAIL reset busy_b: got %b, expected 0", busy_b); end
        checks++; if (done_b !== 1'b0)  begin errors++; $display("FAIL reset done_b: got %b, expected 0", done_b); end
        checks++; if (addr_b !== 5'd0)  begin errors++; $display("FAIL reset dbg_addr_b: got %0d, expected 0", addr_b); end
        low_cnt = 0; done_cnt = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clock);
            if (tx_a !== 1'b1 || tx_b !== 1'b1) low_cnt++;
            if (done_a !== 1'b0 || done_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) done_cnt++;
        end
        checks++; if (low_cnt != 0)  begin errors++; $display("FAIL idle_tx_high: got %0d non-high cycles, expected 0", low_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL idle_quiet: got %0d cycles with busy/done, expected 0", done_cnt); end
    endtask

    task automatic test_single_word();
        byte unsigned exp[$];
        int n_done, done_at, bad;
        mem_a = 32'h0000_00F8;
        // mem_a is overwritten at j=10, after the LOAD capture at j=2
        record(1'b0, WORD_CYC + 20, -1, 10);
        decode();
`ifdef REG_DUMP_HEADER_EN
        exp.push_back(8'h00);
`endif
        exp.push_back(8'hF8); exp.push_back(8'h00); exp.push_back(8'h00); exp.push_back(8'h00);
        checks++;
        if (dec_byte.size() != exp.size()) begin
            errors++; $display("FAIL single byte_count: got %0d, expected %0d", dec_byte.size(), exp.size());
        end
        bad = -1;
        for (int k = 0; k < exp.size() && k < dec_byte.size(); k++)
            if (bad < 0 && dec_byte[k] !== exp[k]) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL single bytes: byte %0d got 0x%02h, expected 0x%02h", bad, dec_byte[bad], exp[bad]);
        end
        bad = -1;
        for (int k = 0; k < dec_pos.size(); k++)
            if (bad < 0 && dec_pos[k] != 3 + k * FRAME_CYC) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL single frame_start: frame %0d at cycle %0d, expected %0d", bad, dec_pos[bad], 3 + bad * FRAME_CYC);
        end
        n_done = 0; done_at = -1;
        for (int j = 0; j < rec_done.size(); j++)
            if (rec_done[j] === 1'b1) begin n_done++; if (done_at < 0) done_at = j; end
        checks++; if (n_done != 1) begin errors++; $display("FAIL single done_count: got %0d, expected 1", n_done); end
        checks++; if (done_at != WORD_CYC - 1) begin errors++; $display("FAIL single done_time: got %0d, expected %0d", done_at, WORD_CYC - 1); end
        checks++;
        if (rec_busy[0] !== 1'b1 || rec_busy[WORD_CYC - 1] !== 1'b1 || rec_busy[WORD_CYC] !== 1'b0) begin
            errors++; $display("FAIL single busy: got %b%b%b at start/done/after, expected 110", rec_busy[0], rec_busy[WORD_CYC - 1], rec_busy[WORD_CYC]);
        end
        mem_a = 32'h0000_00F8;
    endtask

    task automatic test_full_dump();
        byte unsigned exp[$];
        int n_done, done_at, bad;
        record(1'b1, 32 * WORD_CYC + 10, -1, -1);
        decode();
        for (int r = 0; r < 32; r++) begin
`ifdef REG_DUMP_HEADER_EN
            exp.push_back(8'(r));
`endif
            exp.push_back(8'(r)); exp.push_back(8'h00); exp.push_back(8'h00); exp.push_back(8'hA5);
        end
        checks++;
        if (dec_byte.size() != exp.size()) begin
            errors++; $display("FAIL full byte_count: got %0d, expected %0d", dec_byte.size(), exp.size());
        end
        bad = -1;
        for (int k = 0; k < exp.size() && k < dec_byte.size(); k++)
            if (bad < 0 && dec_byte[k] !== exp[k]) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL full bytes: byte %0d got 0x%02h, expected 0x%02h", bad, dec_byte[bad], exp[bad]);
        end
        bad = -1;
        for (int k = 0; k < dec_pos.size(); k++)
            if (bad < 0 && dec_pos[k] != (k / FRAMES) * WORD_CYC + 3 + (k % FRAMES) * FRAME_CYC) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL full frame_start: frame %0d at cycle %0d, expected %0d", bad, dec_pos[bad],
                               (bad / FRAMES) * WORD_CYC + 3 + (bad % FRAMES) * FRAME_CYC);
        end
        bad = -1;
        for (int r = 0; r < 32; r++)
            if (bad < 0 && (rec_addr[r * WORD_CYC] !== 5'(r) || rec_addr[r * WORD_CYC + 2] !== 5'(r))) bad = r;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL full dbg_addr: reg %0d saw addr %0d, expected %0d", bad, rec_addr[bad * WORD_CYC + 2], bad);
        end
        checks++;
        if (rec_addr[32 * WORD_CYC] !== 5'd0) begin
            errors++; $display("FAIL full dbg_addr_end: got %0d, expected 0", rec_addr[32 * WORD_CYC]);
        end
        n_done = 0; done_at = -1;
        for (int j = 0; j < rec_done.size(); j++)
            if (rec_done[j] === 1'b1) begin n_done++; if (done_at < 0) done_at = j; end
        checks++; if (n_done != 1) begin errors++; $display("FAIL full done_count: got %0d, expected 1", n_done); end
        checks++; if (done_at != 32 * WORD_CYC - 1) begin errors++; $display("FAIL full done_time: got %0d, expected %0d", done_at, 32 * WORD_CYC - 1); end
        checks++;
        if (rec_busy[0] !== 1'b1 || rec_busy[32 * WORD_CYC - 1] !== 1'b1 || rec_busy[32 * WORD_CYC] !== 1'b0) begin
            errors++; $display("FAIL full busy: got %b%b%b at start/done/after, expected 110",
                               rec_busy[0], rec_busy[32 * WORD_CYC - 1], rec_busy[32 * WORD_CYC]);
        end
    endtask

    task automatic test_start_while_busy();
        byte unsigned exp[$];
        int n_done, done_at, bad;
        record(1'b1, 32 * WORD_CYC + 60, 50, -1);
        decode();
        for (int r = 0; r < 32; r++) begin
`ifdef REG_DUMP_HEADER_EN
            exp.push_back(8'(r));
`endif
            exp.push_back(8'(r)); exp.push_back(8'h00); exp.push_back(8'h00); exp.push_back(8'hA5);
        end
        checks++;
        if (dec_byte.size() != exp.size()) begin
            errors++; $display("FAIL busy_start byte_count: got %0d, expected %0d", dec_byte.size(), exp.size());
        end
        bad = -1;
        for (int k = 0; k < exp.size() && k < dec_byte.size(); k++)
            if (bad < 0 && dec_byte[k] !== exp[k]) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL busy_start bytes: byte %0d got 0x%02h, expected 0x%02h", bad, dec_byte[bad], exp[bad]);
        end
        n_done = 0; done_at = -1;
        for (int j = 0; j < rec_done.size(); j++)
            if (rec_done[j] === 1'b1) begin n_done++; if (done_at < 0) done_at = j; end
        checks++; if (n_done != 1) begin errors++; $display("FAIL busy_start done_count: got %0d, expected 1", n_done); end
        checks++; if (done_at != 32 * WORD_CYC - 1) begin errors++; $display("FAIL busy_start done_time: got %0d, expected %0d", done_at, 32 * WORD_CYC - 1); end
    endtask

    task automatic test_reset_mid_dump();
        int last, bad;
        // cycle 13 of register 5 is data bit 1 of its first frame (0x05 -> bit1 = 0)
        record(1'b1, 5 * WORD_CYC + 14, -1, -1);
        last = rec_tx.size() - 1;
        checks++; if (rec_tx[last] !== 1'b0) begin errors++; $display("FAIL mid_dump pre_tx: got %b, expected 0", rec_tx[last]); end
        checks++; if (rec_addr[last] !== 5'd5) begin errors++; $display("FAIL mid_dump pre_addr: got %0d, expected 5", rec_addr[last]); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx_b !== 1'b1)   begin errors++; $display("FAIL mid_dump tx: got %b, expected 1", tx_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL mid_dump busy: got %b, expected 0", busy_b); end
        checks++; if (addr_b !== 5'd0) begin errors++; $display("FAIL mid_dump dbg_addr: got %0d, expected 0", addr_b); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        record(1'b1, 2 * WORD_CYC, -1, -1);
        decode();
        checks++;
        if (rec_addr[2] !== 5'd0 || rec_addr[WORD_CYC + 2] !== 5'd1) begin
            errors++; $display("FAIL restart dbg_addr: got %0d,%0d, expected 0,1", rec_addr[2], rec_addr[WORD_CYC + 2]);
        end
        bad = (dec_byte.size() < FRAMES) ? 1 : 0;
        if (bad == 0) begin
`ifdef REG_DUMP_HEADER_EN
            if (dec_byte[0] !== 8'h00 || dec_byte[1] !== 8'h00 || dec_byte[4] !== 8'hA5) bad = 1;
`else
            if (dec_byte[0] !== 8'h00 || dec_byte[3] !== 8'hA5) bad = 1;
`endif
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL restart first_word: got %0d bytes (first 0x%02h), expected register 0 word", dec_byte.size(),
                               (dec_byte.size() > 0) ? dec_byte[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_dump();
        test_start_while_busy();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
Debug dump engine for the register file's debug read port. On a start pulse it walks register addresses 0..NUM_REGS-1 and drives each address onto the debug read port. It captures each returned 32-bit word and transmits it as bytes over a UART 8N1 serial line, LSB byte first. It sits beside the register file in the top level, with the register file's debug clock tied to the same clock as this block.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range >= 2
NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1; legal range 1..32

Ports:
clock  input  1  system clock, also drives the register file debug clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle dump request, sampled on rising clock edge
dbg_addr  output  5  address driven to the register file debug read port
dbg_data  input  32  registered debug read data from the register file
tx  output  1  UART serial output, idle high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset, asynchronous: tx=1, busy=0, done=0, dbg_addr=0, state=IDLE, all counters 0. Applies immediately mid-frame; an aborted frame is not resumed.
- FSM states: IDLE, ADDR, WAIT, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE: tx=1. start=1 -> dbg_addr=0, reg index=0, busy=1, go to ADDR. start while busy is ignored and never queued.
- ADDR: dbg_addr holds the reg index. Go to WAIT.
  - This gives one edge for the debug port to register the data.
- WAIT: one cycle. Go to LOAD.
- LOAD: capture dbg_data into a 32-bit shift word, set byte count=0, go to START_BIT.
  - Capture is on the 3rd rising edge after dbg_addr changes, so it tolerates one registered stage plus margin.
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA_BITS with bit count=0.
- DATA_BITS: tx = current byte bit[bit count], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7 go to STOP_BIT.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
  - If bytes remain for this word: shift word right by 8, increment byte count, go to START_BIT.
  - Else go to NEXT.
- NEXT:
  - If reg index == NUM_REGS-1: busy=0, done=1 for one cycle, dbg_addr=0, go to IDLE.
  - Else: increment reg index, go to ADDR.
- Frames are back-to-back within a word: there are no idle bits between the stop bit and the next start bit.
- Between words there are exactly 3 extra tx-high cycles (NEXT, ADDR, WAIT), plus the LOAD cycle. LOAD keeps tx=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Its width is clog2(CLKS_PER_BIT) bits.
- Bytes per word: 4, or 5 with the optional feature.
- Register contents are sampled per word at LOAD time. Writes to a register after its LOAD are not reflected in the dump.
- start coincident with reset: reset wins.

Optional Feature:
Macro REG_DUMP_HEADER_EN.
- Defined: each word is preceded by a header byte {3'b000, reg index}. Order per register: header, then byte0..byte3, so 5 frames per register. The header is sent from a separate frame before the shift word is used; LOAD still captures at the same point.
- Undefined: no header; 4 frames per register.

Test Plan:
- Reset idle: assert reset for 3 cycles, then release -> tx=1, busy=0, done=0, dbg_addr=0. tx stays high for 100 cycles with start=0.
- Single-word framing: NUM_REGS=1, CLKS_PER_BIT=4, model returns 0x000000F8 for addr 0, pulse start. Expected:
  - tx low for 4 cycles (start bit);
  - then bits 0,0,0,1,1,1,1,1, each for 4 cycles;
  - then high for 4 cycles;
  - then bytes 0x00, 0x00, 0x00 back-to-back;
  - done pulses once, 160 cycles after LOAD.
- Full dump: NUM_REGS=32, CLKS_PER_BIT=4, reg i returns 0xA5000000+i. UART monitor decodes 128 bytes in order (i, 0x00, 0x00, 0xA5) per register, and dbg_addr visits 0..31 in sequence. done occurs exactly 32*(160+4)-1 cycles after the start-accept edge.
- Start while busy: second start pulse 50 cycles into the dump -> byte count and ordering unchanged, exactly one done pulse.
- Reset mid-dump: assert reset during the DATA_BITS phase of register 5 -> tx=1 and busy=0 immediately (same cycle). A new start afterwards dumps from register 0.
- Header variant, REG_DUMP_HEADER_EN defined, NUM_REGS=2, reg1=0x12345678 -> decoded bytes 0x00, r0 bytes, 0x01, 0x78, 0x56, 0x34, 0x12.
